// File: rtl/axi_dma_wr_burst_master.sv
// -----------------------------------------------------------------------------
// axi_dma_wr_burst_master
//
// AXI3 write-burst master for the DMA access path. A command carries a start
// byte address and a total beat count. The stream of write data on in_* is
// carved into AXI3 INCR bursts of at most 16 beats that never cross a 4 KB
// page. Exactly one burst is in flight at a time (AW -> W -> B). The block
// pulses done once the last B response has been collected.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready/addr/beats   command channel (beats == 0 is legal)
//   in_valid/ready/data      write data stream, passed straight through to W
//   done                     one-cycle pulse when a command completes
//   err                      sticky; set when any B response is not OKAY
//   m_aw*                    AXI3 write address channel
//   m_w*                     AXI3 write data channel (all strobes set)
//   m_b*                     AXI3 write response channel (m_bid ignored)
// -----------------------------------------------------------------------------
module axi_dma_wr_burst_master #(
  parameter int ID_WIDTH      = 1,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int AXI_ID        = 0,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]     cmd_beats,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     done,
  output logic                     err,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [ADDRESS_WIDTH-1:0] m_awaddr,
  output logic [ID_WIDTH-1:0]      m_awid,
  output logic [3:0]               m_awlen,
  output logic [2:0]               m_awsize,
  output logic [1:0]               m_awburst,
  output logic [1:0]               m_awlock,
  output logic [3:0]               m_awcache,
  output logic [2:0]               m_awprot,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  output logic [DATA_WIDTH-1:0]    m_wdata,
  output logic [DATA_WIDTH/8-1:0]  m_wstrb,
  output logic                     m_wlast,
  output logic [ID_WIDTH-1:0]      m_wid,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  input  logic [1:0]               m_bresp,
  input  logic [ID_WIDTH-1:0]      m_bid
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]     remaining_q, remaining_d;
  logic [3:0]               awlen_q, awlen_d;      // beats-1 of the current burst
  logic [4:0]               beat_cnt_q, beat_cnt_d; // W beats still to send
  logic                     err_q, err_d;
  logic                     done_q, done_d;

  logic [4:0]               cur_len;
  logic [ADDRESS_WIDTH-1:0] cmd_addr_aligned;
  logic [ADDRESS_WIDTH-1:0] next_addr;
  logic [CNT_WIDTH-1:0]     next_remaining;
  logic                     bid_unused;

  // Burst length: min(16, beats left, beats left before the next 4 KB page).
  // Addresses are beat-aligned, so the page distance divides exactly.
  function automatic logic [4:0] calc_len(input logic [ADDRESS_WIDTH-1:0] a,
                                          input logic [CNT_WIDTH-1:0]     rem);
    logic [12:0] bytes_left;
    logic [12:0] beats_left;
    logic [12:0] l;
    bytes_left = 13'h1000 - {1'b0, a[11:0]};
    beats_left = bytes_left >> SIZE;
    l          = 13'd16;
    if (beats_left < l) l = beats_left;
    if (rem < CNT_WIDTH'(l)) l = 13'(rem);
    return l[4:0];
  endfunction

  assign cur_len          = {1'b0, awlen_q} + 5'd1;
  assign cmd_addr_aligned = cmd_addr & ADDR_MASK;
  assign next_addr        = addr_q + (ADDRESS_WIDTH'(cur_len) << SIZE);
  assign next_remaining   = remaining_q - CNT_WIDTH'(cur_len);
  assign bid_unused       = ^m_bid;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    awlen_d     = awlen_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr_aligned;
          remaining_d = cmd_beats;
          err_d       = 1'b0;
          if (cmd_beats == '0) begin
            done_d = 1'b1;
          end else begin
            awlen_d = 4'(calc_len(cmd_addr_aligned, cmd_beats) - 5'd1);
            state_d = S_AW;
          end
        end
      end
      S_AW: begin
        if (m_awready) begin
          beat_cnt_d = cur_len;
          state_d    = S_W;
        end
      end
      S_W: begin
        if (in_valid && m_wready) begin
          beat_cnt_d = beat_cnt_q - 5'd1;
          if (beat_cnt_q == 5'd1) state_d = S_B;
        end
      end
      S_B: begin
        if (m_bvalid) begin
          if (m_bresp != 2'b00) err_d = 1'b1;
          addr_d      = next_addr;
          remaining_d = next_remaining;
          if (next_remaining == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            awlen_d = 4'(calc_len(next_addr, next_remaining) - 5'd1);
            state_d = S_AW;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      awlen_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      awlen_q     <= awlen_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

  assign m_awvalid = (state_q == S_AW);
  assign m_awaddr  = addr_q;
  assign m_awid    = ID_WIDTH'(AXI_ID);
  assign m_awlen   = awlen_q;
  assign m_awsize  = 3'(SIZE);
  assign m_awburst = 2'b01;
  assign m_awlock  = 2'b00;
  assign m_awcache = 4'b0011;
  assign m_awprot  = 3'b000;

  // W is a pure pass-through of the input stream while a burst is open.
  assign m_wvalid  = (state_q == S_W) && in_valid;
  assign in_ready  = (state_q == S_W) && m_wready;
  assign m_wdata   = in_data;
  assign m_wstrb   = '1;
  assign m_wlast   = (state_q == S_W) && (beat_cnt_q == 5'd1);
  assign m_wid     = ID_WIDTH'(AXI_ID);

  assign m_bready  = (state_q == S_B);

endmodule

// File: tb/tb_axi_dma_wr_burst_master.sv
// -----------------------------------------------------------------------------
// tb_axi_dma_wr_burst_master
//
// Randomised bench for the AXI3 write-burst master. A reference model derives
// the expected burst list (address, length) for each command with plain
// arithmetic, keeps the command's source words in a queue, and tracks which
// channel should be active plus the expected done/err behaviour.
// -----------------------------------------------------------------------------
module tb_axi_dma_wr_burst_master;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int CW    = 16;
  localparam int IDW   = 1;
  localparam int BYTES = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid, cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [CW-1:0]   cmd_beats;
  logic            in_valid, in_ready;
  logic [DW-1:0]   in_data;
  logic            done, err;
  logic            m_awvalid, m_awready;
  logic [AW-1:0]   m_awaddr;
  logic [IDW-1:0]  m_awid;
  logic [3:0]      m_awlen;
  logic [2:0]      m_awsize;
  logic [1:0]      m_awburst, m_awlock;
  logic [3:0]      m_awcache;
  logic [2:0]      m_awprot;
  logic            m_wvalid, m_wready;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_wlast;
  logic [IDW-1:0]  m_wid;
  logic            m_bvalid, m_bready;
  logic [1:0]      m_bresp;
  logic [IDW-1:0]  m_bid;

  always #5 clk = ~clk;

  axi_dma_wr_burst_master #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .AXI_ID(0), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .done(done), .err(err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wid(m_wid),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid)
  );

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model state
  burst_t      aw_q[$];
  logic [31:0] src_q[$];
  bit          active, b_pend, exp_err, exp_done, aw_stall;
  int          w_left, w_cnt, cmd_total, b_idx;
  logic [31:0] stall_addr;
  logic [3:0]  stall_len;

  // Stimulus knobs
  bit          cmd_pend;
  logic [31:0] nxt_addr;
  logic [CW-1:0] nxt_beats;
  int          p_aw, p_w, p_in, p_b, p_err, aw_hold, err_burst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // Split a command into bursts: at most 16 beats, never crossing a 4 KB page.
  task automatic build_bursts(input logic [31:0] addr, input int beats);
    int unsigned a;
    int rem, room, l;
    a   = addr & ~32'(BYTES - 1);
    rem = beats;
    while (rem > 0) begin
      room = int'((4096 - (a % 4096)) / BYTES);
      l = rem;
      if (l > 16) l = 16;
      if (l > room) l = room;
      aw_q.push_back('{a, l});
      a   = a + l * BYTES;
      rem = rem - l;
    end
  endtask

  task automatic clear_model();
    aw_q.delete();
    src_q.delete();
    active = 0; b_pend = 0; exp_err = 0; exp_done = 0; aw_stall = 0;
    w_left = 0; w_cnt = 0; cmd_total = 0; b_idx = 0; cmd_pend = 0;
  endtask

  task automatic cycle();
    burst_t      b;
    logic [31:0] w;
    @(negedge clk);
    check("done", done, exp_done);
    exp_done = 0;
    check("err", err, exp_err);
    if (aw_stall) begin
      check("aw_stall_valid", m_awvalid, 1'b1);
      check("aw_stall_addr", m_awaddr, stall_addr);
      check("aw_stall_len", m_awlen, stall_len);
    end
    aw_stall = 0;

    cmd_valid = cmd_pend;
    cmd_addr  = nxt_addr;
    cmd_beats = nxt_beats;
    in_valid  = (src_q.size() > 0) && chance(p_in);
    in_data   = (src_q.size() > 0) ? src_q[0] : $urandom();
    if (aw_hold > 0) begin
      m_awready = 1'b0;
      if (m_awvalid) aw_hold--;
    end else begin
      m_awready = chance(p_aw);
    end
    m_wready = chance(p_w);
    m_bvalid = b_pend && chance(p_b);
    m_bid    = IDW'($urandom());
    if (b_idx == err_burst) m_bresp = 2'b10;
    else m_bresp = chance(p_err) ? 2'($urandom_range(3, 1)) : 2'b00;
    #1;

    check("cmd_ready", cmd_ready, !active);
    check("awvalid", m_awvalid, active && aw_q.size() > 0 && w_left == 0 && !b_pend);
    check("wvalid", m_wvalid, w_left > 0 && in_valid);
    check("in_ready", in_ready, w_left > 0 && m_wready);
    check("bready", m_bready, b_pend);

    // Handshakes processed latest-phase first so one cycle advances one phase.
    if (m_bvalid && m_bready && b_pend) begin
      if (m_bresp != 2'b00) exp_err = 1;
      b_pend = 0;
      b_idx++;
      if (aw_q.size() == 0) begin
        exp_done = 1;
        active   = 0;
        check("beat_total", w_cnt, cmd_total);
      end
    end
    if (m_wvalid && m_wready && w_left > 0) begin
      w = src_q.pop_front();
      check("wdata", m_wdata, w);
      check("wlast", m_wlast, w_left == 1);
      check("wstrb", m_wstrb, {(DW/8){1'b1}});
      check("wid", m_wid, 0);
      w_left--;
      w_cnt++;
      if (w_left == 0) b_pend = 1;
    end
    if (m_awvalid && aw_q.size() > 0 && w_left == 0 && !b_pend) begin
      if (m_awready) begin
        b = aw_q.pop_front();
        check("awaddr", m_awaddr, b.addr);
        check("awlen", m_awlen, b.len - 1);
        check("awsize", m_awsize, 2);
        check("awburst", {m_awlock, m_awburst}, 4'b0001);
        check("awcache_prot", {m_awcache, m_awprot, m_awid}, {4'b0011, 3'b000, 1'b0});
        w_left = b.len;
      end else begin
        aw_stall   = 1;
        stall_addr = m_awaddr;
        stall_len  = m_awlen;
      end
    end
    if (cmd_valid && cmd_ready) begin
      cmd_pend  = 0;
      exp_err   = 0;
      build_bursts(cmd_addr, int'(cmd_beats));
      for (int i = 0; i < int'(cmd_beats); i++) src_q.push_back($urandom());
      w_cnt     = 0;
      cmd_total = int'(cmd_beats);
      b_idx     = 0;
      if (cmd_beats == '0) exp_done = 1;
      else active = 1;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; in_valid = 1'b1; m_wready = 1'b1;
    m_awready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b10;
    @(posedge clk);
    #1;
    check("rst_awvalid", m_awvalid, 1'b0);
    check("rst_wvalid", m_wvalid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_bready", m_bready, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    m_bvalid = 1'b0;
    clear_model();
  endtask

  task automatic run_cmd(input logic [31:0] a, input int beats, input int paw, input int pw,
                         input int pin, input int pb, input int perr, input int hold,
                         input int eb);
    int n;
    p_aw = paw; p_w = pw; p_in = pin; p_b = pb; p_err = perr;
    aw_hold = hold; err_burst = eb;
    nxt_addr = a; nxt_beats = CW'(beats); cmd_pend = 1;
    n = 0;
    do begin
      cycle();
      n++;
    end while ((cmd_pend || active) && n < 4000);
    if (cmd_pend || active) begin
      check("timeout", cmd_pend || active, 1'b0);
      do_reset();
    end else begin
      cycle();  // done pulse lands here
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    in_valid = 1'b0; in_data = '0; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_bid = '0;
    p_aw = 100; p_w = 100; p_in = 100; p_b = 100; p_err = 0; aw_hold = 0; err_burst = -1;
    nxt_addr = '0; nxt_beats = '0;
    clear_model();
    do_reset();

    run_cmd(32'h1000, 4, 100, 100, 100, 100, 0, 0, -1);
    run_cmd(32'h0000, 40, 100, 100, 100, 100, 0, 0, -1);
    run_cmd(32'h0FF8, 8, 100, 100, 100, 100, 0, 0, -1);
    run_cmd(32'h0200, 30, 60, 50, 50, 70, 0, 5, -1);
    run_cmd(32'h0000, 48, 100, 100, 100, 100, 0, 0, 1);
    run_cmd(32'h3FC3, 20, 100, 100, 100, 100, 0, 0, -1);
    run_cmd(32'h0123, 0, 100, 100, 100, 100, 0, 0, -1);

    for (int k = 0; k < 25; k++) begin
      logic [31:0] a;
      int beats;
      if (chance(50)) a = 32'h1000 * $urandom_range(15) + 32'h1000 - 32'($urandom_range(80, 1));
      else a = $urandom() & 32'h0001_FFFF;
      beats = chance(10) ? 0 : int'($urandom_range(70, 1));
      run_cmd(a, beats, $urandom_range(100, 20), $urandom_range(100, 20),
              $urandom_range(100, 20), $urandom_range(100, 20), 20,
              $urandom_range(3), -1);
    end

    // Reset in the middle of a W burst abandons the command.
    p_aw = 100; p_w = 100; p_in = 100; p_b = 100; p_err = 0; aw_hold = 0; err_burst = -1;
    nxt_addr = 32'h0; nxt_beats = CW'(40); cmd_pend = 1;
    for (int n = 0; n < 50 && w_cnt < 3; n++) cycle();
    do_reset();
    run_cmd(32'h2000, 17, 100, 100, 100, 100, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
